// File: rtl/mul_entry_controller_if.sv
// Keypad/multiplier handshake bundle for mul_entry_controller.
// master = controller side, slave = keypad decoder / storage / multiplier side.
interface mul_entry_controller_if;
  logic [3:0] key_value;
  logic       key_pressed;
  logic       mul_done;
  logic       enable_A;
  logic       enable_B;
  logic       enable_sign;
  logic       digit_strobe;
  logic       clear_all;
  logic       mul_start;
  logic       sign_A;
  logic       sign_B;
  logic [1:0] digit_count;
  logic [1:0] display_sel;
  logic       busy;
  logic       error;

  modport master (
    input  key_value, key_pressed, mul_done,
    output enable_A, enable_B, enable_sign, digit_strobe, clear_all, mul_start,
           sign_A, sign_B, digit_count, display_sel, busy, error
  );

  modport slave (
    output key_value, key_pressed, mul_done,
    input  enable_A, enable_B, enable_sign, digit_strobe, clear_all, mul_start,
           sign_A, sign_B, digit_count, display_sel, busy, error
  );
endinterface

// File: rtl/mul_entry_controller.sv
// Keypad calculator sequencer: key edge detect, operand entry, multiply start/timeout.
// Optional macro RESULT_CHAIN_EN: '*' after a result reloads the result as operand A.
module mul_entry_controller #(
  parameter int         MAX_DIGITS  = 3,
  parameter int         TIMEOUT_CYC = 64,
  parameter logic [3:0] KEY_MUL     = 4'hA,
  parameter logic [3:0] KEY_CLR     = 4'hB,
  parameter logic [3:0] KEY_NEG     = 4'hC,
  parameter logic [3:0] KEY_EQ      = 4'hD
) (
  input  logic clk,
  input  logic rst,
  mul_entry_controller_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, ENTER_A, ENTER_B, START_MUL, WAIT_MUL, SHOW_RESULT
  } state_t;

  state_t        state_q, state_d;
  logic          key_prev_q, key_prev_d;
  logic          key_edge_q, key_edge_d;
  logic [3:0]    key_val_q, key_val_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          strobe_q, strobe_d;
  logic          clr_q, clr_d;
  logic          esign_q, esign_d;
  logic          chain_a_q, chain_a_d;

  logic is_digit, key_ev, digit_room;

  // Key value is captured alongside the edge so both reach the FSM together.
  always_comb begin
    key_prev_d = bus.key_pressed;
    key_edge_d = bus.key_pressed & ~key_prev_q;
    key_val_d  = bus.key_value;
  end

  assign key_ev     = key_edge_q;
  assign is_digit   = (key_val_q <= 4'd9);
  assign digit_room = (cnt_q < 2'(MAX_DIGITS));

  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    strobe_d  = 1'b0;
    clr_d     = 1'b0;
    esign_d   = 1'b0;
    chain_a_d = 1'b0;

    if (key_ev && key_val_q == KEY_CLR) begin
      clr_d    = 1'b1;
      sign_a_d = 1'b0;
      sign_b_d = 1'b0;
      cnt_d    = '0;
      err_d    = 1'b0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_ev && is_digit) begin
            strobe_d = 1'b1;
            cnt_d    = 2'd1;
            state_d  = ENTER_A;
          end else if (key_ev && key_val_q == KEY_NEG) begin
            sign_a_d = ~sign_a_q;
          end
        end
        ENTER_A: begin
          if (key_ev && is_digit) begin
            if (digit_room) begin
              strobe_d = 1'b1;
              cnt_d    = cnt_q + 2'd1;
            end
          end else if (key_ev && key_val_q == KEY_NEG) begin
            sign_a_d = ~sign_a_q;
          end else if (key_ev && key_val_q == KEY_MUL) begin
            esign_d = 1'b1;
            cnt_d   = '0;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (key_ev && is_digit) begin
            if (digit_room) begin
              strobe_d = 1'b1;
              cnt_d    = cnt_q + 2'd1;
            end
          end else if (key_ev && key_val_q == KEY_NEG) begin
            sign_b_d = ~sign_b_q;
          end else if (key_ev && key_val_q == KEY_EQ) begin
            if (cnt_q == 2'd0) err_d   = 1'b1;
            else               state_d = START_MUL;
          end
        end
        START_MUL: state_d = WAIT_MUL;
        WAIT_MUL: begin
          tmo_d = tmo_q + TW'(1);
          // Done on the final allowed cycle wins over the timeout.
          if (bus.mul_done) begin
            state_d = SHOW_RESULT;
          end else if (tmo_q + TW'(1) == TW'(TIMEOUT_CYC)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        SHOW_RESULT: begin
          if (key_ev && is_digit) begin
            clr_d    = 1'b1;
            sign_a_d = 1'b0;
            sign_b_d = 1'b0;
            strobe_d = 1'b1;
            cnt_d    = 2'd1;
            state_d  = ENTER_A;
          end
`ifdef RESULT_CHAIN_EN
          else if (key_ev && key_val_q == KEY_MUL) begin
            chain_a_d = 1'b1;
            esign_d   = 1'b1;
            cnt_d     = '0;
            sign_b_d  = 1'b0;
            state_d   = ENTER_B;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      key_prev_q <= 1'b0;
      key_edge_q <= 1'b0;
      key_val_q  <= '0;
      tmo_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      strobe_q   <= 1'b0;
      clr_q      <= 1'b0;
      esign_q    <= 1'b0;
      chain_a_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_prev_d;
      key_edge_q <= key_edge_d;
      key_val_q  <= key_val_d;
      tmo_q      <= tmo_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      strobe_q   <= strobe_d;
      clr_q      <= clr_d;
      esign_q    <= esign_d;
      chain_a_q  <= chain_a_d;
    end
  end

  assign bus.enable_A     = (state_q == ENTER_A) | chain_a_q;
  assign bus.enable_B     = (state_q == ENTER_B);
  assign bus.enable_sign  = esign_q;
  assign bus.digit_strobe = strobe_q;
  assign bus.clear_all    = clr_q;
  assign bus.mul_start    = (state_q == START_MUL);
  assign bus.sign_A       = sign_a_q;
  assign bus.sign_B       = sign_b_q;
  assign bus.digit_count  = cnt_q;
  assign bus.display_sel  = (state_q == SHOW_RESULT) ? 2'b11 : 2'b00;
  assign bus.busy         = (state_q == START_MUL) | (state_q == WAIT_MUL);
  assign bus.error        = err_q;
endmodule

// File: tb/tb_mul_entry_controller.sv
// Self-checking bench for mul_entry_controller: vector table, corner sequences, random keys vs model.
module tb_mul_entry_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mul_entry_controller_if bus_if();
  mul_entry_controller dut (.clk(clk), .rst(rst), .bus(bus_if));

  int checks = 0, failures = 0, cyc = 0;
  int n_strobe = 0, n_esign = 0, n_clr = 0, n_start = 0, n_ena = 0, start_cyc = 0;
  logic sa_at_start = 1'b0, sb_at_start = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse outputs are counted per high cycle, so a stretched pulse shows as an extra count.
  always @(negedge clk) begin
    n_strobe <= n_strobe + int'(bus_if.digit_strobe);
    n_esign  <= n_esign + int'(bus_if.enable_sign);
    n_clr    <= n_clr + int'(bus_if.clear_all);
    n_ena    <= n_ena + int'(bus_if.enable_A);
    if (bus_if.mul_start) begin
      n_start     <= n_start + 1;
      start_cyc   <= cyc;
      sa_at_start <= bus_if.sign_A;
      sb_at_start <= bus_if.sign_B;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {bus_if.enable_A, bus_if.enable_B, bus_if.enable_sign, bus_if.digit_strobe,
            bus_if.clear_all, bus_if.mul_start, bus_if.sign_A, bus_if.sign_B,
            bus_if.digit_count, bus_if.display_sel, bus_if.busy, bus_if.error};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus_if.key_pressed = 1'b0;
    bus_if.key_value = 4'h0;
    bus_if.mul_done = 1'b0;
    #1 chk("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus_if.key_value = k;
    bus_if.key_pressed = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.key_pressed = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 1000 && cyc < t; i++) @(negedge clk);
    #1;
  endtask

  // mul_done is asserted so that the FSM sees it d cycles after the mul_start cycle.
  task automatic do_done(input int d);
    if (n_start == 0) begin
      chk("mul_start_seen", 32'(n_start), 32'd1);
    end else begin
      for (int i = 0; i < 1000 && cyc < start_cyc + d; i++) @(negedge clk);
      bus_if.mul_done = 1'b1;
      @(negedge clk);
      bus_if.mul_done = 1'b0;
      repeat (2) @(negedge clk);
      #1;
    end
  endtask

  typedef struct {
    string      name;
    int         nk;
    logic [23:0] keys;
    int         done_dly;
    int         e_strobe, e_esign, e_start, e_clr;
    logic       e_sa, e_sb;
    logic [1:0] e_cnt, e_disp;
    logic       e_ena, e_enb, e_err;
  } vec_t;

  vec_t vecs[8];

  // Random-run reference model: spec rules applied per key event.
  int ph, m_strobe, m_esign, m_clr, m_start;
  logic m_sa, m_sb, m_err;
  int m_cnt;

  task automatic model_key(input logic [3:0] k, output bit start);
    start = 1'b0;
    if (k == 4'hB) begin
      m_clr++; m_sa = 0; m_sb = 0; m_cnt = 0; m_err = 0; ph = 0;
    end else if (k <= 4'd9) begin
      if (ph == 0 || ph == 3) begin
        if (ph == 3) begin m_clr++; m_sa = 0; m_sb = 0; end
        m_strobe++; m_cnt = 1; ph = 1;
      end else if (m_cnt < 3) begin
        m_strobe++; m_cnt++;
      end
    end else if (k == 4'hC) begin
      if (ph <= 1) m_sa = !m_sa;
      else if (ph == 2) m_sb = !m_sb;
    end else if (k == 4'hA) begin
      if (ph == 1) begin m_esign++; m_cnt = 0; ph = 2; end
`ifdef RESULT_CHAIN_EN
      else if (ph == 3) begin m_esign++; m_cnt = 0; m_sb = 0; ph = 2; end
`endif
    end else if (k == 4'hD && ph == 2) begin
      if (m_cnt == 0) m_err = 1;
      else begin m_start++; start = 1'b1; end
    end
  endtask

  initial begin
    int b_strobe, b_esign, b_clr, b_start, b_ena;
    bit st;
    logic [3:0] k;
    int dly;

    bus_if.key_pressed = 1'b0;
    bus_if.key_value = 4'h0;
    bus_if.mul_done = 1'b0;

    //             name       nk keys       dly str es st cl sa sb cnt disp enA enB err
    vecs[0] = '{"basic",      5, 24'h0D3A21, 10, 3, 1, 1, 0, 0, 0, 2'd1, 2'd3, 0, 0, 0};
    vecs[1] = '{"maxdig",     4, 24'h004321, -1, 3, 0, 0, 0, 0, 0, 2'd3, 2'd0, 1, 0, 0};
    vecs[2] = '{"signs",      6, 24'hD7CAC5, 10, 2, 1, 1, 0, 1, 1, 2'd1, 2'd3, 0, 0, 0};
    vecs[3] = '{"eq_empty",   3, 24'h000DA5, -1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1};
    vecs[4] = '{"ignored",    5, 24'h09DAFE, -1, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0, 0};
    vecs[5] = '{"neg_idle",   3, 24'h000CCC, -1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0};
    vecs[6] = '{"done_at_to", 4, 24'h00D2A1, 64, 2, 1, 1, 0, 0, 0, 2'd1, 2'd3, 0, 0, 0};
    vecs[7] = '{"clr",        5, 24'h0B3A21, -1, 3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0};

    foreach (vecs[v]) begin
      do_reset();
      b_strobe = n_strobe; b_esign = n_esign; b_start = n_start; b_clr = n_clr;
      for (int i = 0; i < vecs[v].nk; i++) begin
        k = vecs[v].keys[4*i +: 4];
        press(k);
      end
      if (vecs[v].done_dly > 0) do_done(vecs[v].done_dly);
      chk({vecs[v].name, "_strobes"}, 32'(n_strobe - b_strobe), 32'(vecs[v].e_strobe));
      chk({vecs[v].name, "_esign"},   32'(n_esign - b_esign),   32'(vecs[v].e_esign));
      chk({vecs[v].name, "_starts"},  32'(n_start - b_start),   32'(vecs[v].e_start));
      chk({vecs[v].name, "_clears"},  32'(n_clr - b_clr),       32'(vecs[v].e_clr));
      chk({vecs[v].name, "_signA"},   32'(bus_if.sign_A),       32'(vecs[v].e_sa));
      chk({vecs[v].name, "_signB"},   32'(bus_if.sign_B),       32'(vecs[v].e_sb));
      chk({vecs[v].name, "_count"},   32'(bus_if.digit_count),  32'(vecs[v].e_cnt));
      chk({vecs[v].name, "_disp"},    32'(bus_if.display_sel),  32'(vecs[v].e_disp));
      chk({vecs[v].name, "_enA"},     32'(bus_if.enable_A),     32'(vecs[v].e_ena));
      chk({vecs[v].name, "_enB"},     32'(bus_if.enable_B),     32'(vecs[v].e_enb));
      chk({vecs[v].name, "_error"},   32'(bus_if.error),        32'(vecs[v].e_err));
      if (vecs[v].e_start > 0) begin
        chk({vecs[v].name, "_signA_at_start"}, 32'(sa_at_start), 32'(vecs[v].e_sa));
        chk({vecs[v].name, "_signB_at_start"}, 32'(sb_at_start), 32'(vecs[v].e_sb));
      end
    end

    // Clear after the empty-operand error.
    b_clr = n_clr;
    press(4'hB);
    chk("clr_after_err_pulse", 32'(n_clr - b_clr), 32'd1);
    chk("clr_after_err_error", 32'(bus_if.error), 32'd0);
    chk("clr_after_err_enB", 32'(bus_if.enable_B), 32'd0);

    // Two-cycle latency and held key producing a single action.
    do_reset();
    b_strobe = n_strobe;
    @(negedge clk);
    bus_if.key_value = 4'h1;
    bus_if.key_pressed = 1'b1;
    @(negedge clk);
    #1 chk("lat_cycle1_strobe", 32'(bus_if.digit_strobe), 32'd0);
    chk("lat_cycle1_enA", 32'(bus_if.enable_A), 32'd0);
    @(negedge clk);
    #1 chk("lat_cycle2_strobe", 32'(bus_if.digit_strobe), 32'd1);
    chk("lat_cycle2_enA", 32'(bus_if.enable_A), 32'd1);
    @(negedge clk);
    #1 chk("lat_cycle3_strobe", 32'(bus_if.digit_strobe), 32'd0);
    repeat (5) @(negedge clk);
    bus_if.key_pressed = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("held_key_strobes", 32'(n_strobe - b_strobe), 32'd1);
    chk("held_key_count", 32'(bus_if.digit_count), 32'd1);

    // Timeout: last WAIT cycle is 64 after mul_start, IDLE with error the cycle after.
    do_reset();
    press(4'h5); press(4'hA); press(4'h7); press(4'hD);
    wait_until(start_cyc + 64);
    chk("timeout_busy_before", 32'(bus_if.busy), 32'd1);
    chk("timeout_err_before", 32'(bus_if.error), 32'd0);
    @(negedge clk);
    #1 chk("timeout_busy_after", 32'(bus_if.busy), 32'd0);
    chk("timeout_err_after", 32'(bus_if.error), 32'd1);
    chk("timeout_idle", 32'({bus_if.enable_A, bus_if.enable_B, bus_if.display_sel}), 32'd0);

    // Clear while waiting for the multiplier; a late mul_done must be ignored.
    do_reset();
    press(4'h5); press(4'hA); press(4'h7); press(4'hD);
    b_clr = n_clr;
    press(4'hB);
    chk("clr_wait_pulse", 32'(n_clr - b_clr), 32'd1);
    chk("clr_wait_busy", 32'(bus_if.busy), 32'd0);
    @(negedge clk);
    bus_if.mul_done = 1'b1;
    @(negedge clk);
    bus_if.mul_done = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("stray_done_disp", 32'(bus_if.display_sel), 32'd0);

    // Asynchronous reset in the middle of WAIT_MUL.
    do_reset();
    press(4'h5); press(4'hA); press(4'h7); press(4'hD);
    repeat (3) @(negedge clk);
    #1 chk("wait_busy_pre_rst", 32'(bus_if.busy), 32'd1);
    #2 rst = 1'b0;
    #1 chk("async_rst_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // '*' after a result, then a digit starting a fresh entry.
    do_reset();
    press(4'hC); press(4'h2); press(4'hA); press(4'hC); press(4'h3); press(4'hD);
    do_done(7);
    chk("result_disp", 32'(bus_if.display_sel), 32'd3);
    b_ena = n_ena; b_esign = n_esign; b_start = n_start;
    press(4'hA);
`ifdef RESULT_CHAIN_EN
    chk("chain_enA_pulse", 32'(n_ena - b_ena), 32'd1);
    chk("chain_esign", 32'(n_esign - b_esign), 32'd1);
    chk("chain_enB", 32'(bus_if.enable_B), 32'd1);
    chk("chain_signA_kept", 32'(bus_if.sign_A), 32'd1);
    chk("chain_signB_zero", 32'(bus_if.sign_B), 32'd0);
    press(4'h4); press(4'hD);
    chk("chain_start", 32'(n_start - b_start), 32'd1);
    do_done(5);
`else
    chk("nochain_enA", 32'(n_ena - b_ena), 32'd0);
    chk("nochain_esign", 32'(n_esign - b_esign), 32'd0);
    chk("nochain_disp", 32'(bus_if.display_sel), 32'd3);
`endif
    b_clr = n_clr; b_strobe = n_strobe;
    press(4'h8);
    chk("new_entry_clear", 32'(n_clr - b_clr), 32'd1);
    chk("new_entry_strobe", 32'(n_strobe - b_strobe), 32'd1);
    chk("new_entry_signA", 32'(bus_if.sign_A), 32'd0);
    chk("new_entry_enA", 32'(bus_if.enable_A), 32'd1);
    chk("new_entry_count", 32'(bus_if.digit_count), 32'd1);

    // Random key stream against the reference model.
    do_reset();
    ph = 0; m_strobe = 0; m_esign = 0; m_clr = 0; m_start = 0;
    m_sa = 0; m_sb = 0; m_err = 0; m_cnt = 0;
    b_strobe = n_strobe; b_esign = n_esign; b_clr = n_clr; b_start = n_start;
    for (int r = 0; r < 60; r++) begin
      k = 4'($urandom_range(0, 15));
      press(k);
      model_key(k, st);
      if (st) begin
        dly = $urandom_range(3, 70);
        if (dly <= 64) begin
          do_done(dly);
          ph = 3;
        end else begin
          wait_until(start_cyc + 66);
          m_err = 1;
          ph = 0;
        end
      end
      chk("rnd_strobes", 32'(n_strobe - b_strobe), 32'(m_strobe));
      chk("rnd_esign", 32'(n_esign - b_esign), 32'(m_esign));
      chk("rnd_clears", 32'(n_clr - b_clr), 32'(m_clr));
      chk("rnd_starts", 32'(n_start - b_start), 32'(m_start));
      chk("rnd_signA", 32'(bus_if.sign_A), 32'(m_sa));
      chk("rnd_signB", 32'(bus_if.sign_B), 32'(m_sb));
      chk("rnd_count", 32'(bus_if.digit_count), 32'(m_cnt));
      chk("rnd_error", 32'(bus_if.error), 32'(m_err));
      chk("rnd_enA", 32'(bus_if.enable_A), 32'(ph == 1));
      chk("rnd_enB", 32'(bus_if.enable_B), 32'(ph == 2));
      chk("rnd_disp", 32'(bus_if.display_sel), (ph == 3) ? 32'd3 : 32'd0);
      chk("rnd_busy", 32'(bus_if.busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_entry_controller.md
Name: mul_entry_controller

Overview:
- Sequencing FSM for the keypad calculator datapath. It sits between the keypad decoder and the operand-storage / Booth multiplier pair.
- Detects key edges, classifies keys, and drives the storage enables (A, sign, B).
- Issues a one-cycle start to the multiplier, waits for its done signal with a timeout, and selects what the display shows.

Parameters:
- MAX_DIGITS, 3: maximum decimal digits accepted per operand.
- TIMEOUT_CYC, 64: cycles allowed between mul_start and mul_done before error.
- KEY_MUL, 4'hA: key code for '*'.
- KEY_CLR, 4'hB: key code for clear.
- KEY_NEG, 4'hC: key code for sign toggle.
- KEY_EQ, 4'hD: key code for '='.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- key_value  in  4  decoded key code; valid while key_pressed=1
- key_pressed  in  1  debounced key level
- mul_done  in  1  one-cycle pulse from multiplier, result valid
- enable_A  out  1  storage writes operand A
- enable_B  out  1  storage writes operand B
- enable_sign  out  1  storage clears its temp value between operands
- digit_strobe  out  1  one-cycle pulse per accepted digit
- clear_all  out  1  one-cycle pulse clearing storage
- mul_start  out  1  one-cycle multiplier start
- sign_A  out  1  operand A negative
- sign_B  out  1  operand B negative
- digit_count  out  2  digits accepted in current operand
- display_sel  out  2  00=temp, 01=A, 10=B, 11=result
- busy  out  1  high in START_MUL and WAIT_MUL
- error  out  1  sticky timeout or illegal-sequence flag

Behaviour:
- Reset (async, rst=0):
  - FSM goes to IDLE.
  - All outputs 0. display_sel=00. Internal key_prev=0. Timeout counter 0.
- Key edge:
  - key_edge = key_pressed & ~key_prev, registered.
  - Only key_edge cycles act on key_value. Held keys do nothing further.
- Digit classification: key_value<=9 is a digit. Codes E/F are ignored.
- States:
  - IDLE:
    - A digit edge gives digit_strobe=1, digit_count=1, then ENTER_A.
    - KEY_NEG edge toggles sign_A.
    - Other keys are ignored.
  - ENTER_A (enable_A=1, display_sel=00):
    - Digit edge: if digit_count<MAX_DIGITS, pulse digit_strobe and increment digit_count; otherwise ignore (no strobe).
    - KEY_NEG edge toggles sign_A.
    - KEY_MUL edge: pulse enable_sign for 1 cycle, clear digit_count, then ENTER_B.
  - ENTER_B (enable_B=1, display_sel=00):
    - Digits are handled as in ENTER_A.
    - KEY_NEG edge toggles sign_B.
    - KEY_EQ with digit_count=0 sets error and stays in ENTER_B.
    - KEY_EQ with digit_count>0 goes to START_MUL.
  - START_MUL: mul_start=1 for exactly one cycle, then WAIT_MUL unconditionally.
  - WAIT_MUL:
    - Counter increments each cycle.
    - mul_done gives SHOW_RESULT.
    - Counter reaching TIMEOUT_CYC sets error and returns to IDLE.
    - Key edges are ignored except KEY_CLR.
  - SHOW_RESULT (display_sel=11): a digit edge starts a new entry, behaving as from IDLE (with clear_all pulse, signs reset).
- KEY_CLR edge in any state, including WAIT_MUL:
  - Pulses clear_all and zeroes sign_A, sign_B, digit_count and error.
  - Next state is IDLE. This takes priority over all other events that cycle.
- Simultaneous events:
  - mul_done arriving in the same cycle the timeout is reached counts as success: no error, go to SHOW_RESULT.
  - mul_done outside WAIT_MUL is ignored.
- Latency: key edge to state and output change takes 2 cycles (edge register, then FSM register).
- Pulse rule: every pulse output is high for exactly one cycle per triggering event.

Optional Feature:
- Macro: RESULT_CHAIN_EN.
- Defined: KEY_MUL edge in SHOW_RESULT pulses enable_A for one cycle (loads result as A), pulses enable_sign, sets digit_count=0, and goes to ENTER_B. sign_A is unchanged, sign_B=0.
- Undefined: KEY_MUL in SHOW_RESULT is ignored.

Test Plan:
- Keys 1,2,A,3,D, then mul_done 10 cycles after mul_start. Required: 3 digit_strobes; one enable_sign pulse; one mul_start pulse; display_sel=11; error=0.
- Keys 1,2,3,4 in ENTER_A. Required: digit_strobe only for the first 3; digit_count=3.
- Keys 5,C,A,C,7,D. Required: sign_A=1 and sign_B=1 at mul_start.
- Keys 5,A,D. Required: error=1, still in ENTER_B, no mul_start. Then key B: clear_all pulse, error=0, IDLE.
- Start a multiply and withhold mul_done. Required: error=1 and IDLE after 64 cycles. In a separate run, assert rst=0 mid-WAIT_MUL: all outputs 0 immediately.
- With RESULT_CHAIN_EN defined: after a result, keys A,4,D give an enable_A pulse then mul_start. With it undefined, key A has no effect.
